fpu_div16: RTL
==============

# fpu_div16

Multicycle FP16 (IEEE 754 binary16) divider that computes fpuIn1 / fpuIn2. It uses a valid/ready handshake and restoring division, one quotient bit per cycle. It sits beside the single-cycle add/sub unit in the FPU datapath and takes the same fp16_t operands from the FPU top module. It returns a rounded fp16_t result, condition codes and status flags.

## Interface
- No parameters; widths come from shared constants (`FP16_EXPW`=5, `FP16_FRACW`=10, bias 15).
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- inValid  input  1  operands valid.
- inReady  output  1  block can accept operands (high only in IDLE).
- fpuIn1  input  fp16_t  dividend.
- fpuIn2  input  fp16_t  divisor.
- outValid  output  1  result valid; held until accepted.
- outReady  input  1  consumer accepts result.
- fpuOut  output  fp16_t  quotient.
- condCodes  output  condCode_t  {Z,C,N,V}.
- opStatusFlags  output  opStatusFlag_t  {invalid, divZero, overflow, underflow, inexact}.

## Operation
- States: IDLE, PREP, DIV, ROUND, DONE.
- **IDLE**
  - inReady=1.
  - When inValid&&inReady, operands are registered and the FSM goes to PREP.
- **PREP** classifies operands. Special cases load the result and jump to DONE:
  - Any NaN, 0/0, or inf/inf: result 0x7E00 (canonical qNaN), invalid=1.
  - finite nonzero / 0: result ±inf (0x7C00 | sign), divZero=1.
  - inf / finite: result ±inf.
  - 0 / nonzero, or finite / inf: result ±0.
  - Result sign is always sign1^sign2, except for NaN.
- **PREP, general case**
  - Subnormal significands are left-shifted to an implicit 1 using the fpu_lzc11 count. Each subnormal exponent is set to 1−lzc.
  - Quotient exponent is e = eA − eB + 15, held as 8-bit signed.
  - Go to DIV with the iteration counter at 12.
- **DIV** runs 13 iterations, one per cycle:
  - Compute rem' = rem − divisor.
  - If rem' ≥ 0, qbit=1 and rem=rem'; otherwise qbit=0.
  - Shift rem left by 1 and shift q[12:0] left, inserting qbit.
  - Initial rem = dividend significand (12-bit working width). q[12] has weight 2^0.
  - Exit when the counter reaches 0.
- **ROUND**
  - If q[12]==0, shift q left by 1 and set e=e−1.
  - Significand = q[12:2], guard = q[1], sticky = q[0] | (rem≠0).
  - Round to nearest even. A mantissa carry-out increments e.
  - Overflow (e ≥ 31): result ±inf, overflow=1, inexact=1.
  - e ≤ 0: result ±0 (subnormal results flush to zero), underflow=1, inexact=1.
  - inexact = guard|sticky.
  - Go to DONE.
- **DONE**
  - outValid=1.
  - On outReady, go to IDLE and drop outValid in the next cycle.
  - fpuOut and the flags stay stable while outValid && !outReady.
- **condCodes**: Z = (fpuOut[14:0]==0), N = fpuOut.sign, C=0, V=0.
- **Reset values**: FSM=IDLE, inReady=1, outValid=0, fpuOut=0x0000, condCodes=0, opStatusFlags=0.

## Timing
- Acceptance happens at edge 0.
- General case: outValid rises after edge 16 (PREP 1 cycle, DIV 13, ROUND 1, DONE entry 1).
- Special cases: outValid rises after edge 2.
- No new operand is accepted until the result handshake completes, so there is one op in flight. The earliest next acceptance is the cycle after the outValid&&outReady edge.
- Reset in any state forces IDLE at the next edge and discards the partial result. outValid is never asserted for an aborted op.
- inValid while busy is ignored; the producer must hold it.
- Inputs are sampled only on the accepting edge, so later changes to fpuIn1/fpuIn2 have no effect.

## Structure
- Shared package `constants.sv`/`fpu_lib.sv` holds:
  - fp16_t, condCode_t and opStatusFlag_t (gains a divZero field if not already present);
  - the FP16_QNAN (0x7E00) and FP16_INF (0x7C00) constants;
  - the FSM state enum fpuDivState_t.
- One sub-module, fpu_lzc11: combinational 11-bit leading-zero counter, instantiated twice in PREP (once for each operand).

## Test plan
- 0x3C00 / 0x4000 (1.0/2.0) → 0x3800, flags 0, outValid exactly 16 cycles after acceptance.
- 0x3C00 / 0x4200 (1/3) → 0x3555, inexact=1; 0xC500 / 0x4000 (−5/2) → 0xC100, N=1.
- 0x4600 / 0x0000 → 0x7C00 with divZero=1, latency 2. 0x0000 / 0x0000 → 0x7E00 with invalid=1. 0x7E01 / 0x3C00 → 0x7E00 with invalid=1.
- 0x7BFF / 0x1400 → 0x7C00 with overflow and inexact. 0x0001 / 0x3C00 → 0x0000 with underflow, Z=1. 0x0200 / 0x0400 (subnormal/normal) → 0x3800.
- Backpressure: hold outReady=0 for 5 cycles after outValid. fpuOut, flags and outValid must stay stable, inReady=0, and an inValid pulse during this window is ignored.
- Assert reset mid-DIV (cycle 7): IDLE/inReady=1 next cycle, no outValid. A fresh op 0x4400/0x4000 then yields 0x4000.

Source files
------------

// File: rtl/fpu_div16_pkg.sv
// fpu_div16_pkg
// Shared FP16 types and constants for the divider datapath: the binary16
// operand layout, the condition-code and status-flag records returned with
// every result, the canonical NaN/infinity encodings and the divider FSM
// state encoding.
package fpu_div16_pkg;

  localparam int FP16_EXPW  = 5;
  localparam int FP16_FRACW = 10;
  localparam int FP16_BIAS  = 15;
  localparam int FP16_SIGW  = FP16_FRACW + 1;

  // Quotient bits produced: 11 significand bits, a guard bit and one extra
  // bit so a quotient below 1.0 can be normalised by a single left shift.
  localparam int DIV_ITERS = 13;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXPW-1:0]  exp;
    logic [FP16_FRACW-1:0] frac;
  } fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef struct packed {
    logic invalid;
    logic div_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } opStatusFlag_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;
  localparam fp16_t FP16_INF  = 16'h7C00;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    ROUND,
    DONE
  } fpuDivState_t;

  // Z flags a signed zero (sign bit ignored), N mirrors the sign bit.
  // Carry and overflow have no meaning for a divide and are always clear.
  function automatic condCode_t cond_from(input fp16_t val);
    condCode_t cc;
    cc.z = (val.exp == '0) && (val.frac == '0);
    cc.c = 1'b0;
    cc.n = val.sign;
    cc.v = 1'b0;
    return cc;
  endfunction

endpackage

// File: rtl/fpu_div16_lzc11.sv
// fpu_div16_lzc11
// Combinational 11-bit leading-zero counter used to normalise subnormal
// significands before division.
//   value : 11-bit significand (implicit bit in value[10])
//   count : number of zeros above the most significant set bit (11 if zero)
module fpu_div16_lzc11
  import fpu_div16_pkg::*;
(
  input  logic [FP16_SIGW-1:0] value,
  output logic [3:0]           count
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    count = 4'd11;
    for (int i = 0; i < FP16_SIGW; i++) begin
      if (value[i]) begin
        count = 4'(FP16_SIGW - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpu_div16.sv
// fpu_div16
// Multicycle binary16 divider computing fpuIn1 / fpuIn2 with a restoring
// divider that retires one quotient bit per cycle, followed by a single
// round-to-nearest-even step. Special operands (NaN, zero, infinity) are
// resolved without running the divider loop. Subnormal results flush to zero.
//   clock, reset      : clock and synchronous active-high reset
//   inValid / inReady : operand handshake, inReady high only while idle
//   fpuIn1, fpuIn2    : dividend and divisor
//   outValid/outReady : result handshake, result held until accepted
//   fpuOut            : rounded quotient
//   condCodes         : {Z, C, N, V}
//   opStatusFlags     : {invalid, divZero, overflow, underflow, inexact}
module fpu_div16
  import fpu_div16_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          inValid,
  output logic          inReady,
  input  fp16_t         fpuIn1,
  input  fp16_t         fpuIn2,
  output logic          outValid,
  input  logic          outReady,
  output fp16_t         fpuOut,
  output condCode_t     condCodes,
  output opStatusFlag_t opStatusFlags
);

  fpuDivState_t state;
  fpuDivState_t next_state;
  logic         accept;

  fp16_t               op_a;
  fp16_t               op_b;
  logic [11:0]         rem;
  logic [10:0]         divisor;
  logic [12:0]         quo;
  logic signed [7:0]   exp_q;
  logic [3:0]          iter;
  logic                out_valid_q;
  fp16_t               result_q;
  condCode_t           cond_q;
  opStatusFlag_t       flags_q;

  // ------------------------------------------------------------------
  // Operand classification
  // ------------------------------------------------------------------
  logic q_sign;
  logic a_exp_zero, a_exp_max, a_frac_zero;
  logic b_exp_zero, b_exp_max, b_frac_zero;
  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;

  assign q_sign      = op_a.sign ^ op_b.sign;
  assign a_exp_zero  = (op_a.exp == '0);
  assign a_exp_max   = (&op_a.exp);
  assign a_frac_zero = (op_a.frac == '0);
  assign b_exp_zero  = (op_b.exp == '0);
  assign b_exp_max   = (&op_b.exp);
  assign b_frac_zero = (op_b.frac == '0);
  assign a_nan       = a_exp_max & ~a_frac_zero;
  assign a_inf       = a_exp_max &  a_frac_zero;
  assign a_zero      = a_exp_zero & a_frac_zero;
  assign b_nan       = b_exp_max & ~b_frac_zero;
  assign b_inf       = b_exp_max &  b_frac_zero;
  assign b_zero      = b_exp_zero & b_frac_zero;

  // Special-case result selection. Priority matters: the invalid cases
  // are tested first so that inf/inf and 0/0 never fall into the
  // infinity or zero branches, and inf/0 yields infinity without divZero
  // because the dividend is already infinite.
  logic          spec_hit;
  fp16_t         spec_val;
  opStatusFlag_t spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_val   = '0;
    spec_flags = '0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_val           = FP16_QNAN;
      spec_flags.invalid = 1'b1;
    end else if (a_inf) begin
      spec_val      = FP16_INF;
      spec_val.sign = q_sign;
    end else if (b_zero) begin
      spec_val            = FP16_INF;
      spec_val.sign       = q_sign;
      spec_flags.div_zero = 1'b1;
    end else if (a_zero | b_inf) begin
      spec_val.sign = q_sign;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Significand normalisation and quotient exponent
  // ------------------------------------------------------------------
  logic [10:0]       sig_a, sig_b;
  logic [10:0]       sig_a_norm, sig_b_norm;
  logic [3:0]        lzc_a, lzc_b;
  logic signed [7:0] exp_a, exp_b, exp_div;

  assign sig_a = {~a_exp_zero, op_a.frac};
  assign sig_b = {~b_exp_zero, op_b.frac};

  fpu_div16_lzc11 u_lzc_a (
    .value(sig_a),
    .count(lzc_a)
  );

  fpu_div16_lzc11 u_lzc_b (
    .value(sig_b),
    .count(lzc_b)
  );

  // A normal operand has lzc 0, so the shift is a no-op for it. A
  // subnormal gets its leading one moved into the implicit position and
  // its exponent lowered to match (1 - lzc).
  always_comb begin
    sig_a_norm = sig_a << lzc_a;
    sig_b_norm = sig_b << lzc_b;
    exp_a      = a_exp_zero ? (8'sd1 - $signed({4'b0, lzc_a}))
                            : $signed({3'b0, op_a.exp});
    exp_b      = b_exp_zero ? (8'sd1 - $signed({4'b0, lzc_b}))
                            : $signed({3'b0, op_b.exp});
    exp_div    = exp_a - exp_b + 8'(FP16_BIAS);
  end

  // ------------------------------------------------------------------
  // Restoring division step
  // ------------------------------------------------------------------
  // The remainder always stays below twice the divisor, so 12 bits hold
  // it and a plain compare decides the quotient bit.
  logic        qbit;
  logic [11:0] rem_diff;
  logic [11:0] rem_kept;

  always_comb begin
    qbit     = (rem >= {1'b0, divisor});
    rem_diff = rem - {1'b0, divisor};
    rem_kept = qbit ? rem_diff : rem;
  end

  // ------------------------------------------------------------------
  // Normalise, round to nearest even, range check
  // ------------------------------------------------------------------
  logic [12:0]       q_norm;
  logic signed [7:0] e_norm, e_rnd;
  logic              guard, sticky, round_up;
  logic [11:0]       sum;
  logic [9:0]        frac_rnd;
  fp16_t             round_val;
  opStatusFlag_t     round_flags;

  // The quotient of two normalised significands lies in [0.5, 2), so at
  // most one left shift is needed. The doubled remainder is non-zero
  // exactly when bits below q[0] are non-zero, so it folds into sticky.
  always_comb begin
    q_norm = quo;
    e_norm = exp_q;
    if (!quo[12]) begin
      q_norm = {quo[11:0], 1'b0};
      e_norm = exp_q - 8'sd1;
    end
    guard    = q_norm[1];
    sticky   = q_norm[0] | (rem != '0);
    round_up = guard & (sticky | q_norm[2]);
    sum      = {1'b0, q_norm[12:2]} + {11'b0, round_up};
    e_rnd    = sum[11] ? (e_norm + 8'sd1) : e_norm;
    frac_rnd = sum[11] ? sum[10:1] : sum[9:0];

    round_val      = '0;
    round_val.sign = q_sign;
    round_flags    = '0;
    if (e_rnd >= 8'sd31) begin
      round_val.exp         = '1;
      round_flags.overflow  = 1'b1;
      round_flags.inexact   = 1'b1;
    end else if (e_rnd <= 8'sd0) begin
      round_flags.underflow = 1'b1;
      round_flags.inexact   = 1'b1;
    end else begin
      round_val.exp       = e_rnd[4:0];
      round_val.frac      = frac_rnd;
      round_flags.inexact = guard | sticky;
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. DONE is left only once the registered outValid has
  // actually been seen together with outReady.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = PREP;
      PREP:    next_state = spec_hit ? DONE : DIV;
      DIV:     if (iter == 4'd0) next_state = ROUND;
      ROUND:   next_state = DONE;
      DONE:    if (out_valid_q && outReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: the block only listens to inValid while idle.
  always_comb begin
    inReady = (state == IDLE);
    accept  = inValid && (state == IDLE);
  end

  // Datapath registers. Operands are captured only on the accepting edge.
  // The result registers are written once per operation (PREP for special
  // cases, ROUND otherwise) and then held untouched while DONE waits, so
  // the consumer sees a stable result under backpressure. outValid rises
  // one cycle after DONE is entered and clears on the handshake edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a        <= '0;
      op_b        <= '0;
      rem         <= '0;
      divisor     <= '0;
      quo         <= '0;
      exp_q       <= '0;
      iter        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cond_q      <= '0;
      flags_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a <= fpuIn1;
            op_b <= fpuIn2;
          end
        end
        PREP: begin
          if (spec_hit) begin
            result_q <= spec_val;
            flags_q  <= spec_flags;
            cond_q   <= cond_from(spec_val);
          end else begin
            rem     <= {1'b0, sig_a_norm};
            divisor <= sig_b_norm;
            quo     <= '0;
            exp_q   <= exp_div;
            iter    <= 4'(DIV_ITERS - 1);
          end
        end
        DIV: begin
          quo <= {quo[11:0], qbit};
          rem <= rem_kept << 1;
          if (iter != 4'd0) begin
            iter <= iter - 4'd1;
          end
        end
        ROUND: begin
          result_q <= round_val;
          flags_q  <= round_flags;
          cond_q   <= cond_from(round_val);
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (outReady) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign outValid      = out_valid_q;
  assign fpuOut        = result_q;
  assign condCodes     = cond_q;
  assign opStatusFlags = flags_q;

endmodule
